// File: rtl/asignador_pkg.sv
// Shared constants, voice state encoding and width helper for the voice allocator.
package asignador_pkg;

    localparam int unsigned DEF_NUM_KEYS   = 4;
    localparam int unsigned DEF_NUM_VOICES = 2;

    typedef enum logic {
        VOICE_IDLE   = 1'b0,
        VOICE_ACTIVE = 1'b1
    } voice_state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/asignador_voces_detector_flancos.sv
// Per-key edge detector: registers the previous key level and exposes press/release edges.
module detector_flancos
    import asignador_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_NUM_KEYS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] r_key_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_prev <= '0;
        end else begin
            r_key_prev <= key_state;
        end
    end

    assign rise = key_state & ~r_key_prev;
    assign fall = ~key_state & r_key_prev;

endmodule

// File: rtl/asignador_voces.sv
// Voice allocator: shares NUM_VOICES tone generators among NUM_KEYS keys, one press serviced per cycle.
// Define ASIGNADOR_STEAL_EN to steal voices round-robin when all are busy; otherwise such presses are dropped.
module asignador_voces
    import asignador_pkg::*;
#(
    parameter  int unsigned NUM_KEYS   = DEF_NUM_KEYS,
    parameter  int unsigned NUM_VOICES = DEF_NUM_VOICES,
    localparam int unsigned KEY_W      = clog2(NUM_KEYS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         key_state,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       note_on,
    output logic                        all_busy,
    output logic                        drop
);

    localparam int unsigned VOICE_W = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1;

    logic [NUM_KEYS-1:0]   w_rise;
    logic [NUM_KEYS-1:0]   w_fall;
    logic [NUM_KEYS-1:0]   w_eligible;
    logic [NUM_KEYS-1:0]   w_svc_onehot;
    logic [NUM_KEYS-1:0]   w_pending_next;
    logic [NUM_KEYS-1:0]   r_pending_on;
    logic                  w_svc_valid;
    logic [KEY_W-1:0]      w_svc_key;
    logic                  w_held;
    logic                  w_free_found;
    logic [VOICE_W-1:0]    w_free_idx;
    logic [VOICE_W-1:0]    w_alloc_idx;
    logic                  w_alloc_en;
    logic                  w_drop;
    logic [NUM_VOICES-1:0] w_alloc;
    logic [NUM_VOICES-1:0] w_release;
    logic [NUM_VOICES-1:0] r_note_on;
    logic                  r_drop;

    voice_state_t          r_state      [NUM_VOICES];
    voice_state_t          w_state_next [NUM_VOICES];
    logic [KEY_W-1:0]      r_voice_key  [NUM_VOICES];
    logic [KEY_W-1:0]      w_voice_key_next [NUM_VOICES];

`ifdef ASIGNADOR_STEAL_EN
    logic [VOICE_W-1:0]    r_steal_ptr;
    logic [VOICE_W-1:0]    w_steal_ptr_next;
`endif

    detector_flancos #(
        .WIDTH (NUM_KEYS)
    ) u_detector_flancos (
        .clk       (clk),
        .reset     (reset),
        .key_state (key_state),
        .rise      (w_rise),
        .fall      (w_fall)
    );

    // State register: pending presses, per-voice FSM and strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending_on <= '0;
            r_note_on    <= '0;
            r_drop       <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_state[v]     <= VOICE_IDLE;
                r_voice_key[v] <= '0;
            end
        end else begin
            r_pending_on <= w_pending_next;
            r_note_on    <= w_alloc;
            r_drop       <= w_drop;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_state[v]     <= w_state_next[v];
                r_voice_key[v] <= w_voice_key_next[v];
            end
        end
    end

    // Next state: pick lowest pending key not released this edge, then find it a voice
    always_comb begin
        w_eligible   = r_pending_on & ~w_fall;
        w_svc_valid  = |w_eligible;
        w_svc_key    = '0;
        w_svc_onehot = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_svc_key = KEY_W'(k);
            end
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_svc_onehot[k] = w_svc_valid && (w_svc_key == KEY_W'(k));
        end

        w_held       = 1'b0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_release    = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_state[v] == VOICE_IDLE) begin
                w_free_found = 1'b1;
                w_free_idx   = VOICE_W'(v);
            end
            if ((r_state[v] == VOICE_ACTIVE) && (r_voice_key[v] == w_svc_key)) begin
                w_held = 1'b1;
            end
            w_release[v] = (r_state[v] == VOICE_ACTIVE) && w_fall[r_voice_key[v]];
        end

        w_alloc_en  = 1'b0;
        w_alloc_idx = w_free_idx;
        w_drop      = 1'b0;
        if (w_svc_valid && !w_held) begin
            if (w_free_found) begin
                w_alloc_en = 1'b1;
            end else begin
`ifdef ASIGNADOR_STEAL_EN
                w_alloc_en  = 1'b1;
                w_alloc_idx = r_steal_ptr;
`else
                w_drop      = 1'b1;
`endif
            end
        end

        // A (re)assignment wins over a release of the same voice's old key
        w_alloc = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_alloc[v]          = w_alloc_en && (w_alloc_idx == VOICE_W'(v));
            w_state_next[v]     = r_state[v];
            w_voice_key_next[v] = r_voice_key[v];
            if (w_alloc[v]) begin
                w_state_next[v]     = VOICE_ACTIVE;
                w_voice_key_next[v] = w_svc_key;
            end else if (w_release[v]) begin
                w_state_next[v]     = VOICE_IDLE;
            end
        end

        w_pending_next = (r_pending_on | w_rise) & ~w_fall & ~w_svc_onehot;
    end

`ifdef ASIGNADOR_STEAL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_steal_ptr <= '0;
        end else begin
            r_steal_ptr <= w_steal_ptr_next;
        end
    end

    always_comb begin
        w_steal_ptr_next = r_steal_ptr;
        if (w_svc_valid && !w_held && !w_free_found) begin
            w_steal_ptr_next = (r_steal_ptr == VOICE_W'(NUM_VOICES - 1)) ? '0
                             : VOICE_W'(r_steal_ptr + 1'b1);
        end
    end
`endif

    // Outputs decoded from the registered voice state
    always_comb begin
        voice_active = '0;
        voice_key    = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_active[v]                = (r_state[v] == VOICE_ACTIVE);
            voice_key[v*KEY_W +: KEY_W]    = r_voice_key[v];
        end
    end

    assign note_on  = r_note_on;
    assign drop     = r_drop;
    assign all_busy = &voice_active;

endmodule

// File: tb/tb_asignador_voces.sv
// Bench for asignador_voces (4 keys, 2 voices): per-cycle reference model plus directed literal checks.
module tb_asignador_voces;

    localparam int NK = 4;
    localparam int NV = 2;
    localparam int KW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NK-1:0]     key_state = '0;
    logic [NV-1:0]     voice_active;
    logic [NV*KW-1:0]  voice_key;
    logic [NV-1:0]     note_on;
    logic              all_busy;
    logic              drop;

    int n_cmp  = 0;
    int n_fail = 0;

    asignador_voces #(
        .NUM_KEYS   (NK),
        .NUM_VOICES (NV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_state    (key_state),
        .voice_active (voice_active),
        .voice_key    (voice_key),
        .note_on      (note_on),
        .all_busy     (all_busy),
        .drop         (drop)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: keys, a pending set, and a table of voices
    bit [NK-1:0] m_prev, m_pend, m_rise, m_fall;
    bit [NV-1:0] m_act, m_act_old, m_note;
    bit          m_drop, m_held;
    int          m_key [NV];
    int          m_ptr, m_svc, m_free, m_tgt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev = '0; m_pend = '0; m_act = '0; m_note = '0; m_drop = 0; m_ptr = 0;
            for (int v = 0; v < NV; v++) m_key[v] = 0;
        end else begin
            m_rise = key_state & ~m_prev;
            m_fall = ~key_state & m_prev;
            m_svc = -1;
            for (int k = 0; k < NK; k++)
                if (m_svc < 0 && m_pend[k] && !m_fall[k]) m_svc = k;
            m_act_old = m_act;
            m_note = '0;
            m_drop = 0;
            for (int v = 0; v < NV; v++)
                if (m_act_old[v] && m_fall[m_key[v]]) m_act[v] = 0;
            if (m_svc >= 0) begin
                m_held = 0;
                m_free = -1;
                for (int v = 0; v < NV; v++) begin
                    if (m_act_old[v] && m_key[v] == m_svc) m_held = 1;
                    if (m_free < 0 && !m_act_old[v]) m_free = v;
                end
                if (!m_held) begin
                    m_tgt = m_free;
`ifdef ASIGNADOR_STEAL_EN
                    if (m_tgt < 0) begin
                        m_tgt = m_ptr;
                        m_ptr = (m_ptr + 1) % NV;
                    end
`else
                    if (m_tgt < 0) m_drop = 1;
`endif
                    if (m_tgt >= 0) begin
                        m_act[m_tgt]  = 1;
                        m_key[m_tgt]  = m_svc;
                        m_note[m_tgt] = 1;
                    end
                end
            end
            m_pend = (m_pend | m_rise) & ~m_fall;
            if (m_svc >= 0) m_pend[m_svc] = 0;
            m_prev = key_state;
        end
    end

    logic [NV*KW-1:0] exp_vk;

    // Compare DUT against the model every cycle, mid-period
    always @(negedge clk) begin
        if (!reset) begin
            for (int v = 0; v < NV; v++) exp_vk[v*KW +: KW] = KW'(m_key[v]);
            cmp("model_voice_active", 32'(voice_active), 32'(m_act));
            cmp("model_voice_key",    32'(voice_key),    32'(exp_vk));
            cmp("model_note_on",      32'(note_on),      32'(m_note));
            cmp("model_drop",         32'(drop),         32'(m_drop));
            cmp("model_all_busy",     32'(all_busy),     32'(&m_act));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        key_state = '0;
        #12 reset = 1'b0;

        // Single press: two edges to sound
        key_state = 4'b0001;
        step(); cmp("s1_pend_active", 32'(voice_active), 32'h0);
        step(); cmp("s1_active", 32'(voice_active), 32'h1);
                cmp("s1_vkey0", 32'(voice_key[1:0]), 32'h0);
                cmp("s1_note", 32'(note_on), 32'h1);
        step(); cmp("s1_note_clr", 32'(note_on), 32'h0);
                cmp("s1_hold", 32'(voice_active), 32'h1);
        key_state = 4'b0000;
        step(); cmp("s1_release", 32'(voice_active), 32'h0);

        // Two simultaneous presses serviced lowest first
        key_state = 4'b1100;
        step(); cmp("s2_pend", 32'(voice_active), 32'h0);
        step(); cmp("s2_v0", 32'(voice_active), 32'h1);
                cmp("s2_vkey0", 32'(voice_key[1:0]), 32'h2);
                cmp("s2_note0", 32'(note_on), 32'h1);
        step(); cmp("s2_both", 32'(voice_active), 32'h3);
                cmp("s2_vkey1", 32'(voice_key[3:2]), 32'h3);
                cmp("s2_note1", 32'(note_on), 32'h2);
                cmp("s2_busy", 32'(all_busy), 32'h1);
        key_state = 4'b0000;
        step(); cmp("s2_release", 32'(voice_active), 32'h0);

        // All voices busy: steal or drop
        key_state = 4'b0011;
        step(); step(); step();
        cmp("s3_full", 32'(voice_active), 32'h3);
        cmp("s3_keys", 32'(voice_key), 32'h4);
        key_state = 4'b0111;
        step(); step();
`ifdef ASIGNADOR_STEAL_EN
        cmp("s3_steal0_keys", 32'(voice_key), 32'h6);
        cmp("s3_steal0_note", 32'(note_on), 32'h1);
`else
        cmp("s3_drop_pulse", 32'(drop), 32'h1);
        cmp("s3_drop_keys", 32'(voice_key), 32'h4);
        cmp("s3_drop_note", 32'(note_on), 32'h0);
`endif
        step(); cmp("s3_drop_clr", 32'(drop), 32'h0);
        key_state = 4'b1111;
        step(); step();
`ifdef ASIGNADOR_STEAL_EN
        cmp("s3_steal1_keys", 32'(voice_key), 32'hE);
        cmp("s3_steal1_note", 32'(note_on), 32'h2);
`else
        cmp("s3_drop2_pulse", 32'(drop), 32'h1);
`endif
        step();
        key_state = 4'b1110;
        step();
`ifdef ASIGNADOR_STEAL_EN
        cmp("s3_key0_up", 32'(voice_active), 32'h3);
`else
        cmp("s3_key0_up", 32'(voice_active), 32'h2);
`endif
        key_state = 4'b1111;
        step(); step();
        cmp("s3_repress_note", 32'(note_on), 32'h1);
`ifdef ASIGNADOR_STEAL_EN
        cmp("s3_wrap_keys", 32'(voice_key), 32'hC);
`else
        cmp("s3_realloc_keys", 32'(voice_key), 32'h4);
`endif
        key_state = 4'b0000;
        step(); cmp("s3_release", 32'(voice_active), 32'h0);

        // Press released before service never sounds
        key_state = 4'b0001;
        step();
        key_state = 4'b0000;
        step(); cmp("s4_no_note_a", 32'(note_on), 32'h0);
                cmp("s4_no_active", 32'(voice_active), 32'h0);
        step(); cmp("s4_no_note_b", 32'(note_on), 32'h0);
        key_state = 4'b0001;
        step(); step(); cmp("s4_held", 32'(voice_active), 32'h1);
        key_state = 4'b0000;
        step(); cmp("s4_rel_1edge", 32'(voice_active), 32'h0);

        // Reset mid-operation with keys held throughout
        key_state = 4'b0011;
        step(); step(); step();
        cmp("s5_full", 32'(voice_active), 32'h3);
        reset = 1'b1;
        #1;
        cmp("s5_async_clr", 32'(voice_active), 32'h0);
        cmp("s5_async_note", 32'(note_on), 32'h0);
        step();
        reset = 1'b0;
        step(); cmp("s5_pend", 32'(voice_active), 32'h0);
        step(); cmp("s5_v0", 32'(voice_active), 32'h1);
                cmp("s5_vkey0", 32'(voice_key[1:0]), 32'h0);
        step(); cmp("s5_v1", 32'(voice_active), 32'h3);
                cmp("s5_vkey1", 32'(voice_key[3:2]), 32'h1);
        key_state = 4'b0000;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
